tspp_fetch_stage: RTL

- Fetch stage of the two-stage TSPP pipeline.
- Holds the fetch PC and issues word reads to the instruction memory bus.
- Captures returned instructions into the fetch/execute latch consumed by the execute stage.
- Obeys the control unit's update_pc / update_addr / flush / stall commands, including redirects while a bus read is in flight.

---
 rtl/tspp_fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tspp_fetch_stage.sv
// TSPP fetch stage: holds the fetch PC, issues word reads on the instruction bus and fills the
// fetch/execute latch. A one-entry hold buffer absorbs a read that completes while stalled.
module tspp_fetch_stage #(
    parameter int unsigned          WORD_W   = 32,
    parameter logic [WORD_W-1:0]    RESET_PC = 32'h0000_0200
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              update_pc,
    input  logic [WORD_W-1:0] update_addr,
    input  logic              flush,
    input  logic              stall,
    output logic [WORD_W-1:0] imem_addr,
    output logic              imem_ren,
    input  logic              imem_busy,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc4,
    output logic              id_misaligned
);

    typedef enum logic [1:0] {StFetch, StDiscard, StFault} state_e;

    state_e              state_q;
    logic [WORD_W-1:0]   fetch_pc_q;
    logic [WORD_W-1:0]   pending_pc_q;
    logic                hold_full_q;
    logic [WORD_W-1:0]   hold_instr_q;
    logic [WORD_W-1:0]   hold_pc_q;
    logic                id_valid_q;
    logic [WORD_W-1:0]   id_instr_q;
    logic [WORD_W-1:0]   id_pc_q;
    logic [WORD_W-1:0]   id_pc4_q;
    logic                id_misaligned_q;

    logic                aligned;
    logic                completion;
    logic                busy_pending;
    logic                fetch_done;
    logic [WORD_W-1:0]   fetch_pc_plus4;
    logic [WORD_W-1:0]   hold_pc4;

    assign aligned        = (fetch_pc_q[1:0] == 2'b00);
    assign fetch_pc_plus4 = fetch_pc_q + WORD_W'(4);
    assign hold_pc4       = hold_pc_q + WORD_W'(4);

    // Request depends only on registered state, so addr/ren stay stable while busy.
    assign imem_addr    = fetch_pc_q;
    assign imem_ren     = ((state_q == StFetch) && !hold_full_q && aligned) ||
                          (state_q == StDiscard);
    assign completion   = imem_ren && !imem_busy;
    assign busy_pending = imem_ren && imem_busy;
    assign fetch_done   = completion && (state_q == StFetch);

    assign id_valid      = id_valid_q;
    assign id_instr      = id_instr_q;
    assign id_pc         = id_pc_q;
    assign id_pc4        = id_pc4_q;
    assign id_misaligned = id_misaligned_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q         <= StFetch;
            fetch_pc_q      <= RESET_PC;
            pending_pc_q    <= RESET_PC;
            hold_full_q     <= 1'b0;
            hold_instr_q    <= '0;
            hold_pc_q       <= '0;
            id_valid_q      <= 1'b0;
            id_instr_q      <= '0;
            id_pc_q         <= '0;
            id_pc4_q        <= '0;
            id_misaligned_q <= 1'b0;
        end else if (update_pc) begin
            hold_full_q     <= 1'b0;
            id_valid_q      <= 1'b0;
            id_misaligned_q <= 1'b0;
            // A read still waiting on the bus must finish before the redirect takes effect.
            if (busy_pending) begin
                pending_pc_q <= update_addr;
                state_q      <= StDiscard;
            end else begin
                fetch_pc_q <= update_addr;
                state_q    <= StFetch;
            end
        end else begin
            case (state_q)
                StFetch: begin
                    if (completion) begin
                        fetch_pc_q <= fetch_pc_plus4;
                    end else if (!aligned && !stall && !hold_full_q) begin
                        state_q <= StFault;
                    end
                end
                StDiscard: begin
                    if (completion) begin
                        fetch_pc_q <= pending_pc_q;
                        state_q    <= StFetch;
                    end
                end
                StFault: begin
                end
                default: state_q <= StFetch;
            endcase

            if (!stall) begin
                if (hold_full_q) begin
                    id_valid_q      <= 1'b1;
                    id_instr_q      <= hold_instr_q;
                    id_pc_q         <= hold_pc_q;
                    id_pc4_q        <= hold_pc4;
                    id_misaligned_q <= 1'b0;
                    hold_full_q     <= 1'b0;
                end else if (fetch_done) begin
                    id_valid_q      <= 1'b1;
                    id_instr_q      <= imem_rdata;
                    id_pc_q         <= fetch_pc_q;
                    id_pc4_q        <= fetch_pc_plus4;
                    id_misaligned_q <= 1'b0;
                end else if ((state_q == StFetch) && !aligned) begin
                    id_valid_q      <= 1'b1;
                    id_instr_q      <= '0;
                    id_pc_q         <= fetch_pc_q;
                    id_pc4_q        <= fetch_pc_plus4;
                    id_misaligned_q <= 1'b1;
                end else begin
                    id_valid_q <= 1'b0;
                end
            end else if (fetch_done) begin
                hold_full_q  <= 1'b1;
                hold_instr_q <= imem_rdata;
                hold_pc_q    <= fetch_pc_q;
            end

            if (flush) begin
                id_valid_q      <= 1'b0;
                id_misaligned_q <= 1'b0;
            end
        end
    end

endmodule
